// File: rtl/pattern_generator_pkg.sv
// Shared configuration for the pattern generator: default channel count, FSM
// state encodings and the default sample period derived from the system clock.
package pattern_generator_pkg;

  localparam int PG_CHANNEL_COUNT = 8;
  localparam int PG_CLOCK_FREQ    = 50_000_000;
  localparam int PG_SAMPLE_RATE   = 1_000;

  localparam logic [1:0] PG_IDLE = 2'd0;
  localparam logic [1:0] PG_LOAD = 2'd1;
  localparam logic [1:0] PG_RUN  = 2'd2;

  function automatic int pg_bit_period(input int clock_freq, input int sample_rate);
    return clock_freq / sample_rate;
  endfunction

  localparam int PG_BIT_PERIOD = pg_bit_period(PG_CLOCK_FREQ, PG_SAMPLE_RATE);

endpackage

// File: rtl/pattern_generator_ram.sv
// Pattern storage: one write port, one registered read port. A read and a write
// to the same address in one cycle return the old word.
module pattern_ram
  import pattern_generator_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int WIDTH = PG_CHANNEL_COUNT,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Both updates in one block: the read sees the array before this edge's write.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pattern_generator.sv
// Plays a stored multi-channel pattern onto chan_out, one sample per BIT_PERIOD
// clocks, one-shot or looped. Define PATTERN_SYNC_OUT_EN to add the sync_out port.
module pattern_generator
  import pattern_generator_pkg::*;
#(
  parameter int CHANNEL_COUNT = PG_CHANNEL_COUNT,
  parameter int PATTERN_LEN   = 64,
  parameter int BIT_PERIOD    = PG_BIT_PERIOD,
  localparam int AW           = $clog2(PATTERN_LEN),
  localparam int CW           = $clog2(BIT_PERIOD)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     pat_wr_en,
  input  logic [AW-1:0]            pat_wr_addr,
  input  logic [CHANNEL_COUNT-1:0] pat_wr_data,
  output logic [CHANNEL_COUNT-1:0] chan_out,
  output logic                     busy,
  output logic                     done,
  output logic [AW-1:0]            sample_idx,
`ifdef PATTERN_SYNC_OUT_EN
  output logic                     sync_out,
`endif
  output logic [1:0]               fsm_state
);

  localparam logic [CW-1:0] CNT_PRE  = CW'(BIT_PERIOD - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 1);
  localparam logic [AW-1:0] IDX_LAST = AW'(PATTERN_LEN - 1);

  logic [1:0]               state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [AW-1:0]            idx_q, idx_d;
  logic [CHANNEL_COUNT-1:0] chan_q, chan_d;
  logic                     done_q, done_d;
  logic                     rd_en;
  logic [AW-1:0]            rd_addr;
  logic [CHANNEL_COUNT-1:0] rd_data;

  pattern_ram #(
    .DEPTH(PATTERN_LEN),
    .WIDTH(CHANNEL_COUNT)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (pat_wr_en),
    .wr_addr_i (pat_wr_addr),
    .wr_data_i (pat_wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    chan_d  = chan_q;
    done_d  = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    case (state_q)
      PG_IDLE: begin
        chan_d = '0;
        idx_d  = '0;
        cnt_d  = '0;
        if (start && !stop) begin
          state_d = PG_LOAD;
          rd_en   = 1'b1;
        end
      end
      PG_LOAD: begin
        if (stop) begin
          state_d = PG_IDLE;
          chan_d  = '0;
        end else begin
          state_d = PG_RUN;
          chan_d  = rd_data;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      PG_RUN: begin
        if (stop) begin
          state_d = PG_IDLE;
          chan_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          // Prefetch one clock early so the next sample lands with no gap.
          if (cnt_q == CNT_PRE) begin
            rd_en   = 1'b1;
            rd_addr = idx_q + 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST && !loop_en) begin
              state_d = PG_IDLE;
              chan_d  = '0;
              idx_d   = '0;
              done_d  = 1'b1;
            end else begin
              chan_d = rd_data;
              idx_d  = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = PG_IDLE;
        chan_d  = '0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PG_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      chan_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      chan_q  <= chan_d;
      done_q  <= done_d;
    end
  end

`ifdef PATTERN_SYNC_OUT_EN
  logic sync_q;

  // Marks sample 0 of every pass, registered in step with chan_out.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= 1'b0;
    else       sync_q <= (state_d == PG_RUN) && (idx_d == '0);
  end

  assign sync_out = sync_q;
`endif

  assign chan_out   = chan_q;
  assign busy       = (state_q != PG_IDLE);
  assign done       = done_q;
  assign sample_idx = idx_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_pattern_generator.sv
// Scoreboard bench for pattern_generator (BIT_PERIOD=4, PATTERN_LEN=8, 8 channels).
// Compile with PATTERN_SYNC_OUT_EN defined to also check sync_out.
module tb_pattern_generator;
  import pattern_generator_pkg::*;

  localparam int CH = 8;
  localparam int PL = 8;
  localparam int BP = 4;
  localparam int AW = 3;
  localparam int W  = 16;  // {sync, state[1:0], chan[7:0], busy, done, idx[2:0]}
`ifdef PATTERN_SYNC_OUT_EN
  localparam logic [W-1:0] CMP_MASK = '1;
`else
  localparam logic [W-1:0] CMP_MASK = {1'b0, {(W-1){1'b1}}};
`endif

  logic          clk, reset, start, stop, loop_en, pat_wr_en;
  logic [AW-1:0] pat_wr_addr;
  logic [CH-1:0] pat_wr_data, chan_out;
  logic          busy, done;
  logic [AW-1:0] sample_idx;
  logic [1:0]    fsm_state;
`ifdef PATTERN_SYNC_OUT_EN
  logic          sync_out;
`endif

  logic [W-1:0]  exp_q[$];
  logic [CH-1:0] pat [PL];
  int            n_pass = 0;
  int            n_total = 0;

  pattern_generator #(
    .CHANNEL_COUNT(CH),
    .PATTERN_LEN  (PL),
    .BIT_PERIOD   (BP)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .loop_en    (loop_en),
    .pat_wr_en  (pat_wr_en),
    .pat_wr_addr(pat_wr_addr),
    .pat_wr_data(pat_wr_data),
    .chan_out   (chan_out),
    .busy       (busy),
    .done       (done),
    .sample_idx (sample_idx),
`ifdef PATTERN_SYNC_OUT_EN
    .sync_out   (sync_out),
`endif
    .fsm_state  (fsm_state)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [W-1:0] observe();
    logic s;
    s = 1'b0;
`ifdef PATTERN_SYNC_OUT_EN
    s = sync_out;
`endif
    return {s, fsm_state, chan_out, busy, done, sample_idx};
  endfunction

  function automatic logic [W-1:0] pk(input logic [1:0] st, input logic [CH-1:0] ch,
                                      input logic dn, input logic [AW-1:0] idx);
    logic by, sy;
    by = (st != PG_IDLE);
    sy = (st == PG_RUN) && (idx == '0);
    return {sy, st, ch, by, dn, idx};
  endfunction

  // Expected-timeline builders
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(pk(PG_IDLE, '0, 1'b0, '0));
  endtask

  task automatic push_done();
    exp_q.push_back(pk(PG_IDLE, '0, 1'b1, '0));
  endtask

  task automatic push_load();
    exp_q.push_back(pk(PG_LOAD, '0, 1'b0, '0));
  endtask

  task automatic push_sample(input logic [CH-1:0] val, input int idx, input int cycles);
    for (int i = 0; i < cycles; i++) exp_q.push_back(pk(PG_RUN, val, 1'b0, AW'(idx)));
  endtask

  task automatic push_pass(input logic [CH-1:0] p [PL]);
    for (int k = 0; k < PL; k++) push_sample(p[k], k, BP);
  endtask

  // Drivers
  task automatic do_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic load_pattern(input bit rnd);
    for (int k = 0; k < PL; k++) begin
      pat[k] = rnd ? CH'($urandom_range(0, 255)) : (8'h01 << k);
      pat_wr_en = 1'b1; pat_wr_addr = AW'(k); pat_wr_data = pat[k];
      @(posedge clk); #1;
    end
    pat_wr_en = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    logic [W-1:0] exp_w, obs_w;
    int n;
    reset = 1'b1; start = 1'b1; stop = 1'b0; loop_en = 1'b1;
    pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
    exp_q.delete();
    push_idle(4);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      @(posedge clk); #1;
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL reset t=%0d got %h expected %h", t, obs_w, exp_w);
      if (t == 2) begin reset = 1'b0; start = 1'b0; loop_en = 1'b0; end
    end
  endtask

  task automatic test_one_shot();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load(); push_pass(pat); push_done(); push_idle(5);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL one_shot t=%0d got %h expected %h", t, obs_w, exp_w);
      start = (t == 10);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_loop();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load(); push_pass(pat); push_pass(pat); push_done(); push_idle(3);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL loop t=%0d got %h expected %h", t, obs_w, exp_w);
      start   = (t == 10);
      loop_en = (t < 50);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stop();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load(); push_sample(pat[0], 0, 4); push_sample(pat[1], 1, 4);
    push_sample(pat[2], 2, 1); push_idle(5); push_load(); push_pass(pat); push_done();
    push_idle(2);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL stop t=%0d got %h expected %h", t, obs_w, exp_w);
      start = (t == 3 || t == 10 || t == 25);
      stop  = (t == 3 || t == 20);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stop_at_boundary();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load(); push_pass(pat); push_idle(4);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL stop_at_boundary t=%0d got %h expected %h", t, obs_w, exp_w);
      start = (t == 10);
      stop  = (t == 43);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_live_write();
    logic [W-1:0]  exp_w, obs_w;
    logic [CH-1:0] p [PL];
    int n;
    do_reset();
    p = pat;
    p[5] = 8'hAA;
    push_idle(11); push_load(); push_pass(p);
    p[2] = 8'h55;
    push_pass(p); push_done(); push_idle(3);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL live_write t=%0d got %h expected %h", t, obs_w, exp_w);
      start     = (t == 10);
      loop_en   = (t < 50);
      pat_wr_en = (t == 20 || t == 21 || t == 54);
      case (t)
        20:      begin pat_wr_addr = 3'd5; pat_wr_data = 8'hAA; end
        21:      begin pat_wr_addr = 3'd2; pat_wr_data = 8'h55; end
        54:      begin pat_wr_addr = 3'd3; pat_wr_data = 8'h33; end
        default: begin pat_wr_addr = '0;   pat_wr_data = '0;    end
      endcase
      @(posedge clk); #1;
    end
    p[3] = 8'h33;
    pat = p;
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load();
    for (int k = 0; k < 4; k++) push_sample(pat[k], k, BP);
    push_sample(pat[4], 4, 1); push_idle(7); push_load(); push_pass(pat); push_done();
    push_idle(2);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL reset_mid_run t=%0d got %h expected %h", t, obs_w, exp_w);
      start = (t == 10 || t == 35);
      reset = (t == 28);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_w, obs_w;
    int n;
    do_reset();
    push_idle(11); push_load(); push_pass(pat); push_done();
    push_load(); push_pass(pat); push_done(); push_idle(2);
    n = exp_q.size();
    for (int t = 0; t < n; t++) begin
      exp_w = exp_q.pop_front(); obs_w = observe(); n_total++;
      if ((obs_w & CMP_MASK) === (exp_w & CMP_MASK)) n_pass++;
      else $display("FAIL back_to_back t=%0d got %h expected %h", t, obs_w, exp_w);
      start = (t >= 10 && t < 50);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    pat_wr_en = 1'b0; pat_wr_addr = '0; pat_wr_data = '0;
    test_reset();
    load_pattern(1'b0);
    test_one_shot();
    test_loop();
    test_stop();
    test_stop_at_boundary();
    test_live_write();
    test_reset_mid_run();
    load_pattern(1'b1);
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
